ifetch_prefetch_buffer: RTL and testbench
=========================================

IFETCH_PREFETCH_BUFFER -- requirements
Module: ifetch_prefetch_buffer

Interface
REQ-001 SHALL have parameters (name, default, meaning): DEPTH, 2, number of queue entries (2..4); RESET_PC, 32'h80000000, first prefetch address after reset.
REQ-002 SHALL have ports (name direction width meaning):
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- f_ren  in  1  fetch-stage read request
- f_addr  in  32  fetch-stage word address
- f_rdata  out  32  instruction word to the fetch stage
- f_busy  out  1  request not satisfied this cycle
- redirect  in  1  control-flow change; discard all prefetched state
- m_ren  out  1  memory-bus read request
- m_addr  out  32  memory-bus address, always {pf_addr[31:2],2'b00}
- m_rdata  in  32  memory-bus read data
- m_busy  in  1  memory access in progress; low with m_ren = completion

Function
REQ-003 SHALL hold up to DEPTH entries {addr, data} in FIFO order, consecutive word addresses, plus prefetch pointer pf_addr and flag pf_valid.
REQ-004 SHALL implement FSM states IDLE, FETCH, DRAIN; m_ren = 1 in FETCH and DRAIN, 0 in IDLE.
REQ-005 IDLE -> FETCH when pf_valid and queue occupancy < DEPTH; m_addr driven from pf_addr.
REQ-006 In FETCH, m_addr SHALL stay constant until completion (m_busy = 0).
REQ-007 On FETCH completion: push {m_addr, m_rdata} unless bypassed (REQ-010); pf_addr <= pf_addr + 4 (modulo 2^32, 0xFFFFFFFC wraps to 0x00000000); stay FETCH if occupancy after the push is still < DEPTH, else IDLE.
REQ-008 Hit: f_ren = 1, head valid, head.addr[31:2] == f_addr[31:2] -> f_busy = 0, f_rdata = head.data the same cycle, head popped at the clock edge.
REQ-009 Pop and push in the same cycle SHALL both take effect; occupancy unchanged.
REQ-010 Bypass: f_ren = 1, queue empty, state FETCH, m_addr[31:2] == f_addr[31:2], m_busy = 0 -> f_busy = 0, f_rdata = m_rdata, entry not enqueued, pf_addr advances.
REQ-011 Miss (f_ren = 1, neither hit nor bypass): f_busy = 1; SHALL flush the queue, set pf_addr <= f_addr, pf_valid <= 1, unless a FETCH with matching address is in flight (then wait, no flush).
REQ-012 A miss or redirect while in FETCH with a non-matching address SHALL go to DRAIN; the bus request is never aborted.
REQ-013 DRAIN: hold m_ren and m_addr; on completion discard data and go to IDLE (or FETCH if pf_valid). No data SHALL be pushed or forwarded from DRAIN.
REQ-014 redirect = 1: flush queue, pf_valid <= 0, FETCH -> DRAIN; prefetch resumes only after the next miss (REQ-011). redirect has priority over a hit in the same cycle (f_busy = 1).
REQ-015 f_busy = 0 whenever f_ren = 0; f_rdata = 0 when no hit or bypass.
REQ-016 Fetch data SHALL never come from an entry whose address differs from f_addr[31:2].

Reset
REQ-017 nRST low SHALL asynchronously set state = IDLE, queue empty, pf_addr = RESET_PC, pf_valid = 1, so m_ren = 0, m_addr = 0x80000000, f_rdata = 0, f_busy = f_ren.
REQ-018 Reset during FETCH or DRAIN SHALL drop the transaction immediately; no entry survives.

Verification
REQ-019 Cold start: release reset, f_ren = 1 with f_addr = 0x80000000, memory latency 2 -> m_addr 0x80000000 seen, bypass returns word with f_busy = 0 in completion cycle, then 0x80000004 and 0x80000008 prefetched.
REQ-020 Sequential hits: queue holds 0x80000004/0x80000008 (DEPTH = 2), f_ren at 0x80000004 -> f_busy = 0 same cycle, prefetch of 0x8000000C issued.
REQ-021 Redirect during FETCH of 0x80000010 -> m_ren held until m_busy = 0, data discarded, no f_busy = 0 for 0x80000010 until re-requested; m_ren = 0 afterwards until next miss.
REQ-022 Miss to 0x80001000 with full queue -> queue flushed, m_addr = 0x80001000, f_busy = 1 until bypass completion.
REQ-023 Wrap: pf_addr = 0xFFFFFFFC completes -> next m_addr = 0x00000000.
REQ-024 Assert nRST low mid-FETCH -> m_ren = 0 and m_addr = 0x80000000 in the same cycle; no stale hit after release.

Source files
------------

// File: rtl/ifetch_prefetch_buffer_if.sv
// Fetch-stage and memory-bus signal bundle for the instruction prefetch buffer.
// The buffer uses the slave view; the fetch stage / memory side uses master.
interface ifetch_prefetch_buffer_if;
    logic        f_ren;
    logic [31:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_busy;
    logic        redirect;
    logic        m_ren;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;
    logic        m_busy;

    modport slave (
        input  f_ren, f_addr, redirect, m_rdata, m_busy,
        output f_rdata, f_busy, m_ren, m_addr
    );

    modport master (
        output f_ren, f_addr, redirect, m_rdata, m_busy,
        input  f_rdata, f_busy, m_ren, m_addr
    );
endinterface

// File: rtl/ifetch_prefetch_buffer.sv
// Sequential instruction prefetch queue between the fetch stage and a blocking memory bus.
// Serves hits from the queue head, forwards an empty-queue fetch straight from the bus, never aborts a bus read.
module ifetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic                      CLK,
    input logic                      nRST,
    ifetch_prefetch_buffer_if.slave  bus
);
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [29:0]   r_q_addr [DEPTH];
    logic [31:0]   r_q_data [DEPTH];
    logic [CW-1:0] r_count, w_count_nxt, w_wr_idx;
    logic [29:0]   r_pf_addr, w_pf_addr_nxt;
    logic          r_pf_valid, w_pf_valid_nxt;
    logic [29:0]   r_bus_addr;
    logic          w_active, w_complete, w_hit, w_bypass, w_miss;
    logic          w_inflight_match, w_miss_new, w_flush, w_push, w_pop;
    logic          w_can_fetch, w_load_bus;

    always_comb begin
        w_active         = (r_state != IDLE);
        w_complete       = w_active && !bus.m_busy;
        w_inflight_match = (r_state == FETCH) && (r_bus_addr == bus.f_addr[31:2]);
        // redirect suppresses both ways of satisfying a fetch in its cycle
        w_hit    = bus.f_ren && !bus.redirect && (r_count != '0)
                   && (r_q_addr[0] == bus.f_addr[31:2]);
        w_bypass = bus.f_ren && !bus.redirect && (r_count == '0)
                   && w_inflight_match && !bus.m_busy;
        w_miss     = bus.f_ren && !bus.redirect && !w_hit && !w_bypass;
        w_miss_new = w_miss && !w_inflight_match;
        w_flush    = bus.redirect || w_miss_new;
        w_push     = (r_state == FETCH) && w_complete && !w_bypass && !w_flush;
        w_pop      = w_hit;
        w_wr_idx   = r_count - CW'(w_pop);

        w_count_nxt = w_flush ? '0 : r_count + CW'(w_push) - CW'(w_pop);

        w_pf_addr_nxt = r_pf_addr;
        if (w_miss_new)
            w_pf_addr_nxt = bus.f_addr[31:2];
        else if ((r_state == FETCH) && w_complete)
            w_pf_addr_nxt = r_pf_addr + 30'd1;

        w_pf_valid_nxt = r_pf_valid;
        if (bus.redirect)
            w_pf_valid_nxt = 1'b0;
        else if (w_miss_new)
            w_pf_valid_nxt = 1'b1;

        // next-cycle pointer/occupancy decide whether a new read starts
        w_can_fetch = w_pf_valid_nxt && (w_count_nxt < FULL);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_can_fetch) w_state_nxt = FETCH;
            FETCH: begin
                if (w_complete)
                    w_state_nxt = w_can_fetch ? FETCH : IDLE;
                else if (w_flush)
                    w_state_nxt = DRAIN;
            end
            DRAIN: if (w_complete) w_state_nxt = w_can_fetch ? FETCH : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_load_bus = (w_state_nxt == FETCH) && ((r_state != FETCH) || w_complete);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_pf_addr  <= RESET_PC[31:2];
            r_pf_valid <= 1'b1;
            r_bus_addr <= RESET_PC[31:2];
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_addr[i] <= '0;
                r_q_data[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_pf_addr  <= w_pf_addr_nxt;
            r_pf_valid <= w_pf_valid_nxt;
            if (w_load_bus)
                r_bus_addr <= w_pf_addr_nxt;
            if (w_pop) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    r_q_addr[i] <= r_q_addr[i + 1];
                    r_q_data[i] <= r_q_data[i + 1];
                end
            end
            // written after the shift so a same-cycle push lands behind the new head
            if (w_push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == w_wr_idx) begin
                        r_q_addr[i] <= r_bus_addr;
                        r_q_data[i] <= bus.m_rdata;
                    end
                end
            end
        end
    end

    // the bus address stays frozen through FETCH and DRAIN; IDLE shows the prefetch pointer
    assign bus.m_ren   = w_active;
    assign bus.m_addr  = {(r_state == IDLE) ? r_pf_addr : r_bus_addr, 2'b00};
    assign bus.f_busy  = bus.f_ren && !w_hit && !w_bypass;
    assign bus.f_rdata = w_hit ? r_q_data[0] : (w_bypass ? bus.m_rdata : '0);
endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Self-checking bench for ifetch_prefetch_buffer: scoreboard of expected fetch words,
// address-keyed memory model with variable latency, directed scenarios plus random traffic.
module tb_ifetch_prefetch_buffer;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    ifetch_prefetch_buffer_if bus_if ();

    ifetch_prefetch_buffer #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_if)
    );

    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] key      = 32'h1357_9BDF;
    int          lat_cfg  = 2;
    bit          lat_rand = 1'b0;
    int          busy_left = 1;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] bus_log[$];
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    // memory contents depend on the word address and a key that changes on reset
    function automatic logic [31:0] memfn(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ k ^ {w[15:0], w[31:16]};
    endfunction

    function automatic int next_lat();
        return lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < int'(bus_log.size())) return bus_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    // latency = cycles m_ren is high, completion cycle included
    assign bus_if.m_rdata = memfn(bus_if.m_addr, key);
    assign bus_if.m_busy  = bus_if.m_ren && (busy_left != 0);

    always @(posedge CLK or negedge nRST) begin
        if (!nRST)
            busy_left <= lat_cfg - 1;
        else if (!bus_if.m_ren || busy_left == 0)
            busy_left <= next_lat() - 1;
        else
            busy_left <= busy_left - 1;
    end

    // fetch-side monitor: pops the scoreboard whenever the DUT satisfies a request
    always @(negedge CLK) begin
        if (nRST) begin
            if (bus_if.f_ren && !bus_if.f_busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_delivery addr=%h rdata=%h required=no delivery",
                             bus_if.f_addr, bus_if.f_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.addr !== bus_if.f_addr[31:2] || mon_e.data !== bus_if.f_rdata) begin
                        errors++;
                        $display("FAIL fetch_data addr=%h rdata=%h required addr=%h rdata=%h",
                                 bus_if.f_addr, bus_if.f_rdata, {mon_e.addr, 2'b00}, mon_e.data);
                    end
                end
            end else if (bus_if.f_ren) begin
                checks++;
                if (bus_if.f_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL busy_rdata got=%h required=00000000", bus_if.f_rdata);
                end
            end else begin
                checks++;
                if (bus_if.f_busy !== 1'b0 || bus_if.f_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_outputs f_busy=%b f_rdata=%h required 0/00000000",
                             bus_if.f_busy, bus_if.f_rdata);
                end
            end
        end
    end

    // bus-side monitor: a started read keeps m_ren and m_addr until it completes
    always @(negedge CLK or negedge nRST) begin
        if (!nRST) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait) begin
                checks++;
                if (bus_if.m_ren !== 1'b1 || bus_if.m_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL bus_hold m_ren=%b m_addr=%h required 1/%h",
                             bus_if.m_ren, bus_if.m_addr, prev_addr);
                end
            end
            if (bus_if.m_ren && !bus_if.m_busy) bus_log.push_back(bus_if.m_addr);
            prev_wait <= bus_if.m_ren && bus_if.m_busy;
            prev_addr <= bus_if.m_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // issue one fetch request and hold it until the DUT drops f_busy (bounded)
    task automatic fetch(input logic [31:0] a, output int bc, output bit byp);
        exp_t item;
        item.addr = a[31:2];
        item.data = memfn(a, key);
        exp_q.push_back(item);
        bus_if.f_addr = a;
        bus_if.f_ren  = 1'b1;
        bc  = 0;
        byp = 1'b0;
        forever begin
            @(negedge CLK);
            if (!bus_if.f_busy) begin
                byp = bus_if.m_ren && !bus_if.m_busy;
                break;
            end
            bc++;
            if (bc > 60) begin
                checks++;
                errors++;
                $display("FAIL fetch_timeout addr=%h waited=%0d required<=60", a, bc);
                void'(exp_q.pop_back());
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus_if.f_ren = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required=finish before limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        bit          byp;
        int          n;
        int          mcount;
        logic [31:0] a;
        logic [31:0] last;
        int unsigned r;

        bus_if.f_ren    = 1'b1;
        bus_if.f_addr   = RESET_PC;
        bus_if.redirect = 1'b0;
        #22;
        check("reset_m_ren",   {31'h0, bus_if.m_ren}, 32'h0);
        check("reset_m_addr",  bus_if.m_addr, RESET_PC);
        check("reset_f_rdata", bus_if.f_rdata, 32'h0);
        check("reset_f_busy",  {31'h0, bus_if.f_busy}, 32'h1);
        bus_if.f_ren = 1'b0;
        #1;
        check("reset_f_busy_idle", {31'h0, bus_if.f_busy}, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // cold start with latency 2
        fetch(RESET_PC, bc, byp);
        check("cold_busy_cycles", bc, 2);
        check("cold_bypass", {31'h0, byp}, 32'h1);
        wait_cycles(8);
        check("cold_bus_count", bus_log.size(), 3);
        check("cold_bus0", log_at(0), 32'h8000_0000);
        check("cold_bus1", log_at(1), 32'h8000_0004);
        check("cold_bus2", log_at(2), 32'h8000_0008);
        check("cold_full_idle", {31'h0, bus_if.m_ren}, 32'h0);

        // sequential hit refills the queue
        bus_log.delete();
        fetch(32'h8000_0004, bc, byp);
        check("seq_hit_busy", bc, 0);
        wait_cycles(5);
        check("seq_prefetch", log_at(0), 32'h8000_000C);
        check("seq_full_idle", {31'h0, bus_if.m_ren}, 32'h0);

        // redirect during a slow read of 0x80000010
        lat_cfg = 5;
        wait_cycles(1);
        bus_log.delete();
        fetch(32'h8000_0008, bc, byp);
        check("redir_hit_busy", bc, 0);
        check("redir_m_addr", bus_if.m_addr, 32'h8000_0010);
        check("redir_m_ren", {31'h0, bus_if.m_ren}, 32'h1);
        bus_if.redirect = 1'b1;
        @(negedge CLK);
        check("redir_keeps_bus", {31'h0, bus_if.m_ren}, 32'h1);
        @(posedge CLK);
        #1;
        bus_if.redirect = 1'b0;
        n = 0;
        while (bus_log.size() == 0 && n < 30) begin
            @(posedge CLK);
            n++;
        end
        check("drain_addr", log_at(0), 32'h8000_0010);
        mcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus_if.m_ren) mcount++;
        end
        check("no_prefetch_after_redirect", mcount, 0);
        @(posedge CLK);
        #1;
        lat_cfg = 2;
        fetch(32'h8000_000C, bc, byp);
        check("redir_requeue_miss", {31'h0, bc != 0}, 32'h1);
        check("redir_requeue_bypass", {31'h0, byp}, 32'h1);

        // miss with a full queue
        wait_cycles(8);
        bus_log.delete();
        fetch(32'h8000_1000, bc, byp);
        check("miss_busy_cycles", bc, 2);
        check("miss_bypass", {31'h0, byp}, 32'h1);
        check("miss_bus_addr", log_at(0), 32'h8000_1000);
        fetch(32'h8000_0010, bc, byp);
        check("flushed_entry_miss", {31'h0, bc != 0}, 32'h1);

        // redirect beats a hit in the same cycle
        wait_cycles(8);
        bus_if.f_addr   = 32'h8000_0014;
        bus_if.f_ren    = 1'b1;
        bus_if.redirect = 1'b1;
        @(negedge CLK);
        check("redirect_over_hit", {31'h0, bus_if.f_busy}, 32'h1);
        @(posedge CLK);
        #1;
        bus_if.f_ren    = 1'b0;
        bus_if.redirect = 1'b0;
        fetch(32'h8000_0014, bc, byp);
        check("redirect_flushed_miss", {31'h0, bc != 0}, 32'h1);

        // address wrap
        wait_cycles(8);
        bus_log.delete();
        fetch(32'hFFFF_FFFC, bc, byp);
        check("wrap_bypass", {31'h0, byp}, 32'h1);
        wait_cycles(6);
        check("wrap_next_addr", log_at(1), 32'h0000_0000);
        fetch(32'h0000_0000, bc, byp);
        check("wrap_hit_busy", bc, 0);

        // reset in the middle of a read
        wait_cycles(4);
        lat_cfg = 6;
        wait_cycles(1);
        fetch(32'h0000_2000, bc, byp);
        wait_cycles(8);
        check("pre_reset_m_ren", {31'h0, bus_if.m_ren}, 32'h1);
        check("pre_reset_m_busy", {31'h0, bus_if.m_busy}, 32'h1);
        nRST = 1'b0;
        #1;
        check("rst_m_ren", {31'h0, bus_if.m_ren}, 32'h0);
        check("rst_m_addr", bus_if.m_addr, RESET_PC);
        key     = 32'h2468_ACE0;
        lat_cfg = 2;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        fetch(32'h0000_2004, bc, byp);
        check("no_stale_hit", {31'h0, bc != 0}, 32'h1);

        // random traffic
        lat_rand = 1'b1;
        last = 32'h0001_0000;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      a = last + 32'd4;
            else if (r < 72) a = last;
            else if (r < 82) a = last + 32'd8;
            else if (r < 95) a = 32'h0001_0000 + ($urandom_range(0, 255) << 2);
            else             a = 32'hFFFF_FFF4;
            if ($urandom_range(0, 9) == 0) begin
                bus_if.redirect = 1'b1;
                wait_cycles(1);
                bus_if.redirect = 1'b0;
            end
            fetch(a, bc, byp);
            last = a;
            wait_cycles(int'($urandom_range(0, 2)));
        end
        lat_rand = 1'b0;
        wait_cycles(5);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
